// File: rtl/rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// rr_packet_arbiter
//   Round-robin arbiter for one NoC router output port, with wormhole packet
//   locking. The winning input keeps the grant until its tail flit is
//   accepted downstream. A watchdog releases a lock early if a packet runs
//   longer than MAX_PKT_FLITS flits, and records the event in a sticky flag.
//
// Ports
//   clk               in   1        clock, rising edge
//   reset             in   1        synchronous, active-high
//   request           in   NUM_REQ  per-port "has a flit for this output"
//   tail              in   NUM_REQ  per-port "current flit is the packet tail"
//   advance           in   1        downstream accepted the granted flit
//   grant_vec         out  NUM_REQ  registered one-hot grant, zero when idle
//   crossbar_control  out  SEL_W    registered index of the granted port
//   grant_valid       out  1        grant currently held
//   overrun_err       out  1        sticky watchdog-release flag
//   state_dbg         out  1        FSM state (0 = IDLE, 1 = LOCKED)
//
// Handshake: a flit moves from the granted port when advance=1 at a rising
// edge; the arbiter never stalls the flit, it only counts and watches for the
// tail. request is level-sensitive and is only examined when arbitrating.
// -----------------------------------------------------------------------------
module rr_packet_arbiter #(
  parameter int NUM_REQ       = 5,
  parameter int SEL_W         = 3,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] tail,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_vec,
  output logic [SEL_W-1:0]   crossbar_control,
  output logic               grant_valid,
  output logic               overrun_err,
  output logic               state_dbg
);

  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  // Round-robin pick: first requesting port scanning upward from ptr+1.
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;

  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr_q) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (i == cand) && request[i]) begin
          win_found = 1'b1;
          win_idx   = SEL_W'(i);
        end
      end
    end
  end

  // Only the granted port's tail matters; others are masked off.
  logic tail_g;
  logic wd_hit;
  logic release_lock;

  assign tail_g       = |(tail & grant_q);
  assign wd_hit       = (cnt_q == CNT_W'(MAX_PKT_FLITS - 1));
  assign release_lock = advance && (tail_g || wd_hit);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        // advance is meaningless without a grant and is ignored here.
        if (win_found) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d   = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        if (release_lock) begin
          cnt_d = '0;
          if (wd_hit && !tail_g) begin
            overrun_d = 1'b1;
          end
          // ptr_q already equals the releasing port, so the same scan gives
          // it lowest priority and hands over with no idle cycle.
          if (win_found) begin
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            sel_d   = win_idx;
            ptr_d   = win_idx;
          end else begin
            grant_d = '0;
            sel_d   = '0;
            state_d = IDLE;
          end
        end else if (advance && (cnt_q != CNT_W'(MAX_PKT_FLITS))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign grant_vec        = grant_q;
  assign crossbar_control = sel_q;
  assign grant_valid      = |grant_q;
  assign overrun_err      = overrun_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
module tb_rr_packet_arbiter;

  localparam int NUM_REQ = 5;
  localparam int SEL_W   = 3;
  localparam int MAXF    = 4;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] tail;
  logic               advance;
  logic [NUM_REQ-1:0] grant_vec;
  logic [SEL_W-1:0]   crossbar_control;
  logic               grant_valid;
  logic               overrun_err;
  logic               state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  rr_packet_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .SEL_W        (SEL_W),
    .MAX_PKT_FLITS(MAXF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .request         (request),
    .tail            (tail),
    .advance         (advance),
    .grant_vec       (grant_vec),
    .crossbar_control(crossbar_control),
    .grant_valid     (grant_valid),
    .overrun_err     (overrun_err),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] tl;
    logic               adv;
    logic [NUM_REQ-1:0] eg;
    logic [SEL_W-1:0]   es;
    logic               eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [NUM_REQ-1:0] req,
                              input logic [NUM_REQ-1:0] tl, input logic adv,
                              input logic [NUM_REQ-1:0] eg, input logic [SEL_W-1:0] es,
                              input logic eo);
    vec_t v;
    v.rst = rst; v.req = req; v.tl = tl; v.adv = adv;
    v.eg = eg; v.es = es; v.eo = eo;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, sample 1 time unit after rise
  task automatic drive(input logic rst, input logic [NUM_REQ-1:0] req,
                       input logic [NUM_REQ-1:0] tl, input logic adv);
    @(negedge clk);
    reset   = rst;
    request = req;
    tail    = tl;
    advance = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input logic [NUM_REQ-1:0] eg,
                               input logic [SEL_W-1:0] es, input logic eo);
    check("grant_vec", idx, 32'(grant_vec), 32'(eg));
    check("crossbar_control", idx, 32'(crossbar_control), 32'(es));
    check("grant_valid", idx, 32'(grant_valid), 32'(eg != '0));
    check("overrun_err", idx, 32'(overrun_err), 32'(eo));
    check("state_dbg", idx, 32'(state_dbg), 32'(eg != '0));
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_g;
    int                 waited;
    reset   = 1'b1;
    request = '0;
    tail    = '0;
    advance = 1'b0;

    //   rst req       tail      adv  exp_grant exp_sel eo
    // rotation with single-flit packets, no bubble
    add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0);
    add(0, 5'b11100, 5'b11111, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b11100, 5'b11111, 1, 5'b01000, 3'd3, 0);
    add(0, 5'b11100, 5'b11111, 1, 5'b10000, 3'd4, 0);
    add(0, 5'b11100, 5'b11111, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b11100, 5'b11111, 1, 5'b01000, 3'd3, 0);
    // 3-flit packet on port 1 with a stall in the middle
    add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0);
    add(0, 5'b01110, 5'b00000, 0, 5'b00010, 3'd1, 0);
    add(0, 5'b01110, 5'b00000, 1, 5'b00010, 3'd1, 0);
    add(0, 5'b01110, 5'b00000, 0, 5'b00010, 3'd1, 0);
    add(0, 5'b01110, 5'b00000, 1, 5'b00010, 3'd1, 0);
    add(0, 5'b01110, 5'b00010, 1, 5'b00100, 3'd2, 0);
    // port 2 single flit hands over to port 3
    add(0, 5'b01000, 5'b00100, 1, 5'b01000, 3'd3, 0);
    // port 3 stalled, request dropped midway, tail without advance ignored
    add(0, 5'b01000, 5'b00000, 0, 5'b01000, 3'd3, 0);
    add(0, 5'b01000, 5'b00000, 0, 5'b01000, 3'd3, 0);
    add(0, 5'b01000, 5'b00000, 0, 5'b01000, 3'd3, 0);
    add(0, 5'b00000, 5'b01000, 0, 5'b01000, 3'd3, 0);
    add(0, 5'b00000, 5'b01000, 0, 5'b01000, 3'd3, 0);
    add(0, 5'b00000, 5'b01000, 0, 5'b01000, 3'd3, 0);
    // counter unchanged by stall: watchdog fires on the 4th advance
    add(0, 5'b10000, 5'b00000, 1, 5'b01000, 3'd3, 0);
    add(0, 5'b10000, 5'b00000, 1, 5'b01000, 3'd3, 0);
    add(0, 5'b10000, 5'b00000, 1, 5'b01000, 3'd3, 0);
    add(0, 5'b10000, 5'b00000, 1, 5'b10000, 3'd4, 1);
    // port 4 overruns too; other ports' tails ignored; wrap to port 0
    add(0, 5'b10001, 5'b01111, 1, 5'b10000, 3'd4, 1);
    add(0, 5'b10001, 5'b01111, 1, 5'b10000, 3'd4, 1);
    add(0, 5'b10001, 5'b01111, 1, 5'b10000, 3'd4, 1);
    add(0, 5'b10001, 5'b01111, 1, 5'b00001, 3'd0, 1);
    // reset clears sticky flag; alternating single-flit packets
    add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0);
    add(0, 5'b10010, 5'b11111, 1, 5'b00010, 3'd1, 0);
    add(0, 5'b10010, 5'b11111, 1, 5'b10000, 3'd4, 0);
    add(0, 5'b10010, 5'b11111, 1, 5'b00010, 3'd1, 0);
    add(0, 5'b10010, 5'b11111, 1, 5'b10000, 3'd4, 0);
    add(0, 5'b00000, 5'b11111, 1, 5'b00000, 3'd0, 0);
    add(0, 5'b00000, 5'b11111, 1, 5'b00000, 3'd0, 0);
    // tail coinciding with watchdog limit: no overrun; lone requester re-wins
    add(0, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 0);
    add(0, 5'b00100, 5'b00100, 1, 5'b00100, 3'd2, 0);
    // reset while locked on port 2, then port 0 has first priority
    add(0, 5'b11111, 5'b00000, 0, 5'b00100, 3'd2, 0);
    add(1, 5'b11111, 5'b11111, 1, 5'b00000, 3'd0, 0);
    add(0, 5'b11111, 5'b00000, 0, 5'b00001, 3'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].tl, vecs[i].adv);
      check_outputs(i, vecs[i].eg, vecs[i].es, vecs[i].eo);
    end

    // full rotation across all ports with single-flit packets
    drive(1'b1, '0, '0, 1'b0);
    check_outputs(100, '0, '0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 5'b11111, 5'b11111, 1'b1);
      exp_g = '0;
      exp_g[k % NUM_REQ] = 1'b1;
      check_outputs(101 + k, exp_g, SEL_W'(k % NUM_REQ), 1'b0);
    end

    // bounded wait for a grant after reset
    drive(1'b1, '0, '0, 1'b0);
    waited = 0;
    drive(1'b0, 5'b00010, 5'b00000, 1'b0);
    while (!grant_valid && waited < 4) begin
      drive(1'b0, 5'b00010, 5'b00000, 1'b0);
      waited++;
    end
    check("grant_latency_cycles", 200, 32'(waited), 32'd0);
    check("grant_vec_after_wait", 201, 32'(grant_vec), 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
